// File: rtl/float_add_issue.sv
// Issue stage in front of the multi-cycle float adder: queues operand pairs,
// resolves zero/special operands locally and launches the rest one at a time.
module float_add_issue #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [31:0]              InOp1,
  input  logic [31:0]              InOp2,
  input  logic                     InValid,
  output logic                     InReady,
  output logic [31:0]              AddOp1,
  output logic [31:0]              AddOp2,
  output logic                     AddInputValid,
  input  logic [31:0]              AddResult,
  input  logic                     AddResultValid,
  output logic [31:0]              OutResult,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic                     Busy,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Error
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]      QNAN      = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  function automatic logic is_zero(input logic [31:0] f);
    return (f[30:23] == 8'h00) && (f[22:0] == 23'h0);
  endfunction

  function automatic logic is_special(input logic [31:0] f);
    return f[30:23] == 8'hFF;
  endfunction

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;

  logic [31:0]       op1_mem [DEPTH];
  logic [31:0]       op2_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic [31:0]       head_op1;
  logic [31:0]       head_op2;

  assign InReady  = (Count != FULL_CNT);
  assign push     = InValid && InReady;
  assign pop      = (state == S_IDLE) && (Count != '0) && !OutValid;
  assign head_op1 = op1_mem[rd_ptr];
  assign head_op2 = op2_mem[rd_ptr];
  assign Busy     = (state != S_IDLE);

  // Operand storage carries no reset; the pointers define what is live.
  always_ff @(posedge Clock) begin
    if (push) begin
      op1_mem[wr_ptr] <= InOp1;
      op2_mem[wr_ptr] <= InOp2;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   Count <= Count + 1'b1;
        2'b01:   Count <= Count - 1'b1;
        default: ;
      endcase
    end
  end

  // Issue/return sequencer: IDLE pops, ISSUE pulses the adder, WAIT collects, HOLD hands off.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      AddOp1        <= '0;
      AddOp2        <= '0;
      AddInputValid <= 1'b0;
      OutResult     <= '0;
      OutValid      <= 1'b0;
      Error         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            if (is_special(head_op1) || is_special(head_op2)) begin
              OutResult <= is_special(head_op1) ? head_op1 : head_op2;
              OutValid  <= 1'b1;
              state     <= S_HOLD;
            end else if (is_zero(head_op1) || is_zero(head_op2)) begin
              OutResult <= is_zero(head_op1) ? head_op2 : head_op1;
              OutValid  <= 1'b1;
              state     <= S_HOLD;
            end else begin
              AddOp1        <= head_op1;
              AddOp2        <= head_op2;
              AddInputValid <= 1'b1;
              state         <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          AddInputValid <= 1'b0;
          wait_cnt      <= '0;
          state         <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // A valid seen on the first WAIT cycle belongs to the previous operation.
          if (AddResultValid && (wait_cnt != '0)) begin
            OutResult <= AddResult;
            OutValid  <= 1'b1;
            state     <= S_HOLD;
          end else if (wait_cnt == LAST_WAIT) begin
            OutResult <= QNAN;
            OutValid  <= 1'b1;
            Error     <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (OutReady) begin
            OutValid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_add_issue.sv
// Directed bench for float_add_issue with a small behavioural adder model
// whose latency, silence and stuck-valid behaviour are set per test.
module tb_float_add_issue;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic                   Clock = 1'b0;
  logic                   Reset;
  logic [31:0]            InOp1;
  logic [31:0]            InOp2;
  logic                   InValid;
  logic                   InReady;
  logic [31:0]            AddOp1;
  logic [31:0]            AddOp2;
  logic                   AddInputValid;
  logic [31:0]            AddResult;
  logic                   AddResultValid = 1'b0;
  logic [31:0]            OutResult;
  logic                   OutValid;
  logic                   OutReady;
  logic                   Busy;
  logic [$clog2(DEPTH):0] Count;
  logic                   Error;

  int total = 0;
  int bad   = 0;

  // Adder model controls and observations
  logic        stuck = 1'b0;
  logic        mute  = 1'b0;
  int          lat   = 6;
  int          cd    = 0;
  int          launches = 0;
  logic [31:0] l_op1 = '0;
  logic [31:0] l_op2 = '0;
  logic        model_rv;

  float_add_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset),
    .InOp1(InOp1), .InOp2(InOp2), .InValid(InValid), .InReady(InReady),
    .AddOp1(AddOp1), .AddOp2(AddOp2), .AddInputValid(AddInputValid),
    .AddResult(AddResult), .AddResultValid(AddResultValid),
    .OutResult(OutResult), .OutValid(OutValid), .OutReady(OutReady),
    .Busy(Busy), .Count(Count), .Error(Error)
  );

  always #5 Clock = ~Clock;

  // Adder answers lat cycles after a launch; the pending answer survives a DUT reset.
  always @(negedge Clock) begin
    model_rv = stuck;
    if (AddInputValid) begin
      launches = launches + 1;
      l_op1 = AddOp1;
      l_op2 = AddOp2;
      if (!mute) cd = lat;
    end else if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) model_rv = 1'b1;
    end
    AddResultValid = model_rv;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
    InOp1   = a;
    InOp2   = b;
    InValid = 1'b1;
    tick();
    InValid = 1'b0;
  endtask

  task automatic wait_out(input int max, output int cyc);
    cyc = 0;
    while (!OutValid && cyc < max) begin
      tick();
      cyc++;
    end
    check("out_valid_wait", 32'(OutValid), 32'd1);
  endtask

  initial begin
    int          cyc;
    int          n0;
    int          hi;
    logic [31:0] exp_q [$];

    Reset = 1'b1; InValid = 1'b0; InOp1 = '0; InOp2 = '0;
    OutReady = 1'b1; AddResult = '0;
    tick(); tick();
    check("rst_out_result", OutResult, 32'h0);
    check("rst_out_valid",  32'(OutValid), 32'd0);
    check("rst_add_valid",  32'(AddInputValid), 32'd0);
    check("rst_error",      32'(Error), 32'd0);
    check("rst_count",      32'(Count), 32'd0);
    check("rst_in_ready",   32'(InReady), 32'd1);
    check("rst_busy",       32'(Busy), 32'd0);
    check("rst_add_op1",    AddOp1, 32'h0);
    check("rst_add_op2",    AddOp2, 32'h0);
    Reset = 1'b0;
    tick();

    // 1.0 + 2.0 through the adder, 6-cycle answer
    AddResult = 32'h4040_0000; lat = 6; n0 = launches;
    push_pair(32'h3F80_0000, 32'h4000_0000);
    wait_out(40, cyc);
    check("add_latency", cyc, 8);
    check("add_result", OutResult, 32'h4040_0000);
    check("add_launches", launches - n0, 1);
    check("add_op1", l_op1, 32'h3F80_0000);
    check("add_op2", l_op2, 32'h4000_0000);
    tick();
    check("add_valid_one_cycle", 32'(OutValid), 32'd0);
    check("add_idle", 32'(Busy), 32'd0);

    // zero operand bypass
    n0 = launches;
    push_pair(32'h0000_0000, 32'h4040_0000);
    wait_out(10, cyc);
    check("zero_latency", cyc, 1);
    check("zero_result", OutResult, 32'h4040_0000);
    check("zero_no_launch", launches - n0, 0);
    tick();

    // infinity bypass
    push_pair(32'h7F80_0000, 32'h3F80_0000);
    wait_out(10, cyc);
    check("inf_latency", cyc, 1);
    check("inf_result", OutResult, 32'h7F80_0000);
    check("inf_no_launch", launches - n0, 0);
    tick();

    // fill the FIFO behind a held result
    OutReady = 1'b0;
    push_pair(32'h0000_0000, 32'h4100_0000);
    push_pair(32'h4200_0000, 32'h0000_0000);
    push_pair(32'h3F80_0000, 32'hFF80_0000);
    push_pair(32'h7FC0_0001, 32'h7F80_0000);
    push_pair(32'h0000_0000, 32'h0000_0000);
    check("full_count", 32'(Count), 32'd4);
    check("full_in_ready", 32'(InReady), 32'd0);
    check("hold_valid", 32'(OutValid), 32'd1);
    check("hold_result", OutResult, 32'h4100_0000);
    push_pair(32'h0000_0000, 32'h4300_0000);
    check("full_refused", 32'(Count), 32'd4);
    exp_q = '{32'h4100_0000, 32'h4200_0000, 32'hFF80_0000, 32'h7FC0_0001, 32'h0000_0000};
    OutReady = 1'b1;
    foreach (exp_q[k]) begin
      wait_out(10, cyc);
      check("drain_order", OutResult, exp_q[k]);
      tick();
    end
    check("drain_empty", 32'(Count), 32'd0);

    // second fill across the pointer wrap, one entry via the adder
    OutReady = 1'b0; AddResult = 32'h3F80_0000; lat = 3; n0 = launches;
    push_pair(32'h0000_0000, 32'h4080_0000);
    push_pair(32'h40E0_0000, 32'h0000_0000);
    push_pair(32'h0000_0001, 32'h3F80_0000);
    push_pair(32'hFF80_0000, 32'h0000_0000);
    push_pair(32'h0000_0000, 32'h8000_0000);
    check("wrap_count", 32'(Count), 32'd4);
    exp_q = '{32'h4080_0000, 32'h40E0_0000, 32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000};
    OutReady = 1'b1;
    foreach (exp_q[k]) begin
      wait_out(20, cyc);
      check("wrap_order", OutResult, exp_q[k]);
      tick();
    end
    check("wrap_launches", launches - n0, 1);
    check("wrap_denorm_op1", l_op1, 32'h0000_0001);

    // stale valid held high: first WAIT cycle ignored
    stuck = 1'b1; mute = 1'b1; AddResult = 32'h40A0_0000;
    push_pair(32'h4000_0000, 32'h4040_0000);
    wait_out(20, cyc);
    check("stuck_latency", cyc, 4);
    check("stuck_result", OutResult, 32'h40A0_0000);
    tick();
    stuck = 1'b0;

    // adder never answers
    push_pair(32'h3F80_0000, 32'h3F80_0000);
    wait_out(TIMEOUT + 20, cyc);
    check("timeout_latency", cyc, TIMEOUT + 2);
    check("timeout_result", OutResult, 32'h7FC0_0000);
    check("timeout_error", 32'(Error), 32'd1);
    tick();
    push_pair(32'h0000_0000, 32'h3F80_0000);
    wait_out(10, cyc);
    check("after_timeout_result", OutResult, 32'h3F80_0000);
    check("error_sticky", 32'(Error), 32'd1);
    tick();
    mute = 1'b0;

    // reset in WAIT with a queued entry and a late adder answer
    lat = 6; AddResult = 32'h4040_0000;
    push_pair(32'h3F80_0000, 32'h4000_0000);
    push_pair(32'h0000_0000, 32'h4100_0000);
    tick(); tick();
    check("wait_busy", 32'(Busy), 32'd1);
    check("wait_count", 32'(Count), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_count", 32'(Count), 32'd0);
    check("midrst_error", 32'(Error), 32'd0);
    check("midrst_add_op1", AddOp1, 32'h0);
    check("midrst_out_result", OutResult, 32'h0);
    check("midrst_in_ready", 32'(InReady), 32'd1);
    hi = 0;
    repeat (12) begin
      tick();
      if (OutValid || AddInputValid) hi++;
    end
    check("late_valid_ignored", hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
